// File: rtl/key_code_lock.sv
// rtl/key_code_lock.sv - keypad code lock with programmable code, lockout and idle relock
module key_code_lock #(
    parameter logic [15:0] CODE_INIT      = 16'h1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd5000000,
    parameter logic [23:0] OPEN_CYCLES    = 24'd10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    input  logic       dav,
    output logic       unlocked,
    output logic       lockout,
    output logic       err,
    output logic       prog_done,
    output logic [2:0] digit_count
);

    localparam logic [2:0]  MAX_FAIL_L   = 3'(MAX_FAIL);
    localparam logic [23:0] OPEN_LAST    = OPEN_CYCLES - 24'd1;
    localparam logic [23:0] LOCKOUT_LAST = LOCKOUT_CYCLES - 24'd1;
    localparam logic [3:0]  KEY_STAR     = 4'hA;
    localparam logic [3:0]  KEY_HASH     = 4'hB;

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] code, code_nxt;
    logic [15:0] buffer, buffer_nxt;
    logic [2:0]  count_nxt;
    logic [2:0]  fail_cnt, fail_nxt, fail_inc;
    logic [23:0] timer, timer_nxt, timer_inc;
    logic        err_nxt, prog_nxt;

    logic        sync1, sync2, sync3;
    logic [2:0]  sync_valid;
    logic        armed;
    logic        kev;
    logic        is_digit, is_star, is_hash;
    logic        pass;

    // Synchronize dav and arm the key detector only after two real low samples,
    // so a key held through reset release or a held key never re-triggers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            sync_valid <= 3'b000;
            armed      <= 1'b0;
        end else begin
            sync1      <= dav;
            sync2      <= sync1;
            sync3      <= sync2;
            sync_valid <= {sync_valid[1:0], 1'b1};
            if (kev) begin
                armed <= 1'b0;
            end else if (sync_valid[2] && !sync2 && !sync3) begin
                armed <= 1'b1;
            end
        end
    end

    assign kev       = sync2 & armed;
    assign is_digit  = (d <= 4'd9);
    assign is_star   = (d == KEY_STAR);
    assign is_hash   = (d == KEY_HASH);
    assign pass      = (digit_count == 3'd4) && (buffer == code);
    assign fail_inc  = (fail_cnt >= MAX_FAIL_L) ? fail_cnt : fail_cnt + 3'd1;
    assign timer_inc = (timer == 24'hFFFFFF) ? timer : timer + 24'd1;

    // Next-state, datapath and pulse decode for the lock controller.
    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        buffer_nxt = buffer;
        count_nxt  = digit_count;
        fail_nxt   = fail_cnt;
        timer_nxt  = timer_inc;
        err_nxt    = 1'b0;
        prog_nxt   = 1'b0;

        case (state)
            S_LOCKED: begin
                timer_nxt = 24'd0;
                if (kev) begin
                    if (is_digit) begin
                        if (digit_count < 3'd4) begin
                            buffer_nxt = {buffer[11:0], d};
                            count_nxt  = digit_count + 3'd1;
                        end
                    end else if (is_star) begin
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end else if (is_hash) begin
                        state_nxt = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                timer_nxt  = 24'd0;
                buffer_nxt = 16'h0000;
                count_nxt  = 3'd0;
                if (pass) begin
                    state_nxt = S_OPEN;
                    fail_nxt  = 3'd0;
                end else begin
                    err_nxt  = 1'b1;
                    fail_nxt = fail_inc;
                    if (fail_inc == MAX_FAIL_L) begin
                        state_nxt = S_LOCKOUT;
                    end else begin
                        state_nxt = S_LOCKED;
                    end
                end
            end

            S_OPEN: begin
                if (kev && (is_digit || is_star || is_hash)) begin
                    timer_nxt = 24'd0;
                    if (is_digit) begin
                        if (digit_count < 3'd4) begin
                            buffer_nxt = {buffer[11:0], d};
                            count_nxt  = digit_count + 3'd1;
                        end
                    end else if (is_star) begin
                        state_nxt  = S_LOCKED;
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end else begin
                        if (digit_count == 3'd4) begin
                            code_nxt = buffer;
                            prog_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        buffer_nxt = 16'h0000;
                        count_nxt  = 3'd0;
                    end
                end else if (timer >= OPEN_LAST) begin
                    state_nxt  = S_LOCKED;
                    timer_nxt  = 24'd0;
                    buffer_nxt = 16'h0000;
                    count_nxt  = 3'd0;
                end
            end

            S_LOCKOUT: begin
                if (timer >= LOCKOUT_LAST) begin
                    state_nxt = S_LOCKED;
                    timer_nxt = 24'd0;
                    fail_nxt  = 3'd0;
                end
            end

            default: begin
                state_nxt = S_LOCKED;
                timer_nxt = 24'd0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_LOCKED;
            code        <= CODE_INIT;
            buffer      <= 16'h0000;
            digit_count <= 3'd0;
            fail_cnt    <= 3'd0;
            timer       <= 24'd0;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
            err         <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            code        <= code_nxt;
            buffer      <= buffer_nxt;
            digit_count <= count_nxt;
            fail_cnt    <= fail_nxt;
            timer       <= timer_nxt;
            unlocked    <= (state_nxt == S_OPEN);
            lockout     <= (state_nxt == S_LOCKOUT);
            err         <= err_nxt;
            prog_done   <= prog_nxt;
        end
    end

endmodule

// File: tb/tb_key_code_lock.sv
// tb/tb_key_code_lock.sv - directed self-checking bench for key_code_lock
module tb_key_code_lock;

    localparam int OPEN_N    = 60;
    localparam int LOCKOUT_N = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d;
    logic       dav;
    logic       unlocked, lockout, err, prog_done;
    logic [2:0] digit_count;

    int total = 0;
    int bad   = 0;
    int err_seen  = 0;
    int prog_seen = 0;
    int both_seen = 0;

    key_code_lock #(
        .CODE_INIT      (16'h1234),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (24'(LOCKOUT_N)),
        .OPEN_CYCLES    (24'(OPEN_N))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d           (d),
        .dav         (dav),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .err         (err),
        .prog_done   (prog_done),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (err === 1'b1) err_seen++;
            if (prog_done === 1'b1) prog_seen++;
            if (err === 1'b1 && prog_done === 1'b1) both_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        d   = k;
        dav = 1'b1;
        repeat (6) @(negedge clk);
        dav = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic enter(input logic [15:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            press(code[4*i +: 4]);
        end
        press(4'hB);
    endtask

    initial begin
        reset = 1'b0;
        d     = 4'h0;
        dav   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_unlocked", {31'd0, unlocked}, 32'd0);
        check("rst_lockout", {31'd0, lockout}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_prog", {31'd0, prog_done}, 32'd0);
        check("rst_count", {29'd0, digit_count}, 32'd0);

        // dav already high at release must not count
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("held_at_release", {29'd0, digit_count}, 32'd0);
        dav = 1'b0;
        repeat (6) @(negedge clk);

        // 1,2,3,4,# with exact unlock timing
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("count4", {29'd0, digit_count}, 32'd4);
        d = 4'hB; dav = 1'b1;
        repeat (3) @(negedge clk);
        check("check_cycle_locked", {31'd0, unlocked}, 32'd0);
        @(negedge clk);
        check("unlock_after_check", {31'd0, unlocked}, 32'd1);
        check("count_cleared", {29'd0, digit_count}, 32'd0);
        dav = 1'b0;
        repeat (6) @(negedge clk);
        check("pass_no_err", err_seen, 32'd0);

        // idle relock exactly OPEN_N cycles after the last accepted key
        d = 4'h7; dav = 1'b1;
        repeat (3) @(negedge clk);
        dav = 1'b0;
        check("open_digit", {29'd0, digit_count}, 32'd1);
        repeat (OPEN_N - 1) @(negedge clk);
        check("open_before_timeout", {31'd0, unlocked}, 32'd1);
        @(negedge clk);
        check("open_timeout", {31'd0, unlocked}, 32'd0);
        check("timeout_clears", {29'd0, digit_count}, 32'd0);
        repeat (6) @(negedge clk);

        // held key counts once; codes C-F ignored; '*' clears
        d = 4'h5; dav = 1'b1;
        repeat (1000) @(negedge clk);
        dav = 1'b0;
        repeat (6) @(negedge clk);
        check("held_one_digit", {29'd0, digit_count}, 32'd1);
        press(4'hC);
        check("code_c_ignored", {29'd0, digit_count}, 32'd1);
        press(4'hA);
        check("star_clears", {29'd0, digit_count}, 32'd0);

        // two wrong entries, third enters lockout
        enter(16'h0123, 3);
        check("wrong1_err", err_seen, 32'd1);
        enter(16'h9999, 4);
        check("wrong2_err", err_seen, 32'd2);
        check("wrong2_locked", {31'd0, unlocked}, 32'd0);
        press(4'h5);
        d = 4'hB; dav = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_lockout", {31'd0, lockout}, 32'd0);
        @(negedge clk);
        check("lockout_entry", {31'd0, lockout}, 32'd1);
        dav = 1'b0;
        repeat (6) @(negedge clk);
        press(4'h1);
        check("lockout_ignores_key", {29'd0, digit_count}, 32'd0);
        repeat (LOCKOUT_N - 19) @(negedge clk);
        check("lockout_last_cycle", {31'd0, lockout}, 32'd1);
        @(negedge clk);
        check("lockout_release", {31'd0, lockout}, 32'd0);
        check("wrong3_err", err_seen, 32'd3);
        repeat (6) @(negedge clk);

        // fail count cleared by lockout exit
        enter(16'h0001, 1);
        check("post_lockout_fail", {31'd0, lockout}, 32'd0);
        check("post_lockout_err", err_seen, 32'd4);
        enter(16'h1234, 4);
        check("reopen", {31'd0, unlocked}, 32'd1);
        press(4'hA);
        check("star_relock", {31'd0, unlocked}, 32'd0);

        // digit saturation
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'h6);
        check("count_saturates", {29'd0, digit_count}, 32'd4);
        press(4'hB);
        check("sat_pass", {31'd0, unlocked}, 32'd1);

        // programming in OPEN
        enter(16'h0012, 2);
        check("prog_short_err", err_seen, 32'd5);
        check("prog_short_open", {31'd0, unlocked}, 32'd1);
        enter(16'h7701, 4);
        check("prog_done_once", prog_seen, 32'd1);
        check("prog_no_err", err_seen, 32'd5);
        check("prog_stays_open", {31'd0, unlocked}, 32'd1);
        press(4'hA);
        enter(16'h7701, 4);
        check("new_code_opens", {31'd0, unlocked}, 32'd1);
        press(4'hA);
        enter(16'h1234, 4);
        check("old_code_err", err_seen, 32'd6);
        check("old_code_locked", {31'd0, unlocked}, 32'd0);

        // reset during lockout reverts code
        enter(16'h0001, 1);
        enter(16'h0001, 1);
        check("lockout_again", {31'd0, lockout}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_lockout", {31'd0, lockout}, 32'd0);
        check("async_unlocked", {31'd0, unlocked}, 32'd0);
        check("async_err", {31'd0, err}, 32'd0);
        check("async_prog", {31'd0, prog_done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        enter(16'h1234, 4);
        check("init_code_after_reset", {31'd0, unlocked}, 32'd1);
        check("err_prog_exclusive", both_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
